udp_rx_arbiter: RTL and testbench
=================================

UDP_RX_ARBITER -- requirements
Module: udp_rx_arbiter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 4: idle cycles inserted after every frame end or abort (0 allowed).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: consecutive no-transfer cycles in STREAM before abort (range 1..65535).
REQ-003 SHALL have port main_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port main_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req0_byte  input  8  requester 0 Ethernet byte (preamble/SFD included).
REQ-006 SHALL have port req0_valid  input  1  requester 0 byte available; held until accepted.
REQ-007 SHALL have port req0_last  input  1  qualifies req0_byte as final byte of frame.
REQ-008 SHALL have port req0_ready  output  1  arbiter accepts req0_byte this cycle.
REQ-009 SHALL have ports req1_byte/req1_valid/req1_last (input) and req1_ready (output), identical semantics for requester 1.
REQ-010 SHALL have port eth_byte  output  8  byte to downstream UDP parser.
REQ-011 SHALL have port input_ready  output  1  eth_byte valid this cycle (one-cycle strobe per byte).
REQ-012 SHALL have port grant  output  2  one-hot current owner; 2'b00 when none.
REQ-013 SHALL have port frame_abort  output  1  one-cycle pulse on timeout.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, STREAM, GAP.
REQ-016 IDLE: with any reqN_valid high, SHALL enter STREAM next cycle with grant set to the chosen requester; otherwise SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin per frame: both valid -> grant the requester not granted last; only one valid -> grant it.
REQ-018 last_grant SHALL update at every grant decision; after reset requester 0 SHALL have priority.
REQ-019 reqN_ready SHALL be high iff state==STREAM and grant selects N (decoded from registers only, no input-to-output path); never high for both.
REQ-020 Transfer SHALL occur on cycles with reqN_valid & reqN_ready high; non-granted requester SHALL be held off with ready low.
REQ-021 Each transfer SHALL register eth_byte <= reqN_byte and input_ready <= 1 on the next cycle (latency 1); input_ready SHALL be 0 on non-transfer cycles; eth_byte holds its last value.
REQ-022 Transfer with reqN_last high SHALL move to GAP next cycle and clear grant to 2'b00.
REQ-023 Frames SHALL never interleave: once granted, ownership SHALL persist until last-byte transfer or abort.
REQ-024 Stall counter SHALL reset to 0 on entry to STREAM and on every transfer, increment otherwise; reaching TIMEOUT_CYCLES SHALL pulse frame_abort for one cycle, clear grant, enter GAP.
REQ-025 Simultaneous transfer and timeout in the same cycle: transfer SHALL win, no abort.
REQ-026 GAP SHALL last exactly IFG_CYCLES cycles with both readies low, then IDLE; IFG_CYCLES==0 SHALL go from STREAM directly to IDLE.
REQ-027 Arbitration in IDLE SHALL use valid levels present in that cycle; a requester raising valid during GAP SHALL wait for IDLE.
REQ-028 Gap counter width SHALL cover IFG_CYCLES; stall counter 16 bits; neither SHALL wrap.

Reset
REQ-029 main_rst high SHALL, at the next edge, force state=IDLE, grant=0, input_ready=0, frame_abort=0, busy=0, eth_byte=8'h00, counters=0, last_grant=requester 1.
REQ-030 Reset mid-frame SHALL abandon the frame without frame_abort; reset SHALL take precedence over every other event.

Verification
REQ-031 Single frame on req0 (7x55, D5, 50 payload bytes, last on final): grant=01, 58 input_ready strobes, eth_byte equals stream delayed 1 cycle, then 4 GAP cycles, busy low.
REQ-032 Both requesters valid from reset, 3 frames each: grants alternate 01,10,01,10,01,10; no byte interleaving; IFG of 4 between frames.
REQ-033 req1 granted, drops valid for 255 cycles mid-frame: frame_abort single pulse on cycle 255, grant=00, req0 granted after GAP.
REQ-034 req0 valid returns exactly on stall count 254: transfer occurs, no abort, frame completes.
REQ-035 main_rst asserted mid-frame on req1: next cycle all outputs zero, IDLE; next frame grant goes to req0 if both valid.
REQ-036 IFG_CYCLES=0, back-to-back frames on req0 only: IDLE re-grant one cycle after last transfer, only one bubble cycle on input_ready.

Source files
------------

// File: rtl/udp_rx_arbiter.sv
// udp_rx_arbiter: two-requester, frame-granular round-robin arbiter that
// feeds one Ethernet byte stream into a downstream UDP parser.
//
// Ports:
//   main_clk, main_rst          clock, synchronous active-high reset
//   reqN_byte/valid/last        requester N byte stream (N = 0, 1)
//   reqN_ready                  requester N byte accepted this cycle
//   eth_byte, input_ready       registered output byte and its strobe
//   grant                       one-hot current owner, 2'b00 when none
//   frame_abort                 one-cycle pulse when a frame stalls out
//   busy                        high whenever the arbiter is not IDLE
module udp_rx_arbiter #(
  parameter int IFG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       main_clk,
  input  logic       main_rst,
  input  logic [7:0] req0_byte,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_byte,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] eth_byte,
  output logic       input_ready,
  output logic [1:0] grant,
  output logic       frame_abort,
  output logic       busy
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
  // Abort fires on the no-transfer cycle that would bring the stall count
  // to TIMEOUT_CYCLES, so the counter itself never has to hold that value.
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t           state, state_nx;
  logic [1:0]       grant_q, grant_nx;
  logic             last_grant, last_grant_nx;   // 1: requester 1 owned last
  logic [15:0]      stall_cnt, stall_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic [7:0]       eth_q, eth_nx;
  logic             ir_q, ir_nx;
  logic             abort_q, abort_nx;

  logic             xfer;
  logic             pick1;
  logic [7:0]       sel_byte;
  logic             sel_last;

  assign req0_ready  = (state == STREAM) && grant_q[0];
  assign req1_ready  = (state == STREAM) && grant_q[1];
  assign eth_byte    = eth_q;
  assign input_ready = ir_q;
  assign grant       = grant_q;
  assign frame_abort = abort_q;
  assign busy        = (state != IDLE);

  assign sel_byte = grant_q[1] ? req1_byte : req0_byte;
  assign sel_last = grant_q[1] ? req1_last : req0_last;
  assign xfer     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  // Requester 1 wins when it is alone, or when both ask and 0 owned last.
  assign pick1    = req1_valid && (!req0_valid || !last_grant);

  always_comb begin
    state_nx      = state;
    grant_nx      = grant_q;
    last_grant_nx = last_grant;
    stall_nx      = stall_cnt;
    gap_nx        = gap_cnt;
    eth_nx        = eth_q;
    ir_nx         = 1'b0;
    abort_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_nx      = pick1 ? 2'b10 : 2'b01;
          last_grant_nx = pick1;
          stall_nx      = '0;
          state_nx      = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          eth_nx   = sel_byte;
          ir_nx    = 1'b1;
          stall_nx = '0;
        end else if (stall_cnt < STALL_LAST) begin
          stall_nx = stall_cnt + 16'd1;
        end else begin
          abort_nx = 1'b1;
        end
        if ((xfer && sel_last) || abort_nx) begin
          grant_nx = 2'b00;
          stall_nx = '0;
          gap_nx   = '0;
          state_nx = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt >= GAP_LAST) begin
          gap_nx   = '0;
          state_nx = IDLE;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      state      <= IDLE;
      grant_q    <= 2'b00;
      last_grant <= 1'b1;
      stall_cnt  <= '0;
      gap_cnt    <= '0;
      eth_q      <= 8'h00;
      ir_q       <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      grant_q    <= grant_nx;
      last_grant <= last_grant_nx;
      stall_cnt  <= stall_nx;
      gap_cnt    <= gap_nx;
      eth_q      <= eth_nx;
      ir_q       <= ir_nx;
      abort_q    <= abort_nx;
    end
  end

endmodule

// File: tb/tb_udp_rx_arbiter.sv
// Testbench for udp_rx_arbiter: scoreboarded byte stream, grant order,
// timeout, reset and zero-IFG scenarios.
module tb_udp_rx_arbiter;

  logic       main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  logic       main_rst;
  logic [7:0] req0_byte, req1_byte;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic       req0_ready, req1_ready;
  logic [7:0] eth_byte;
  logic       input_ready, frame_abort, busy;
  logic [1:0] grant;

  // second instance with no inter-frame gap
  logic       b_rst;
  logic [7:0] b0_byte, b_eth;
  logic       b0_valid, b0_last, b0_ready, b1_ready, b_ir, b_abort, b_busy;
  logic [1:0] b_grant;

  udp_rx_arbiter #(.IFG_CYCLES(4), .TIMEOUT_CYCLES(255)) dut (
    .main_clk(main_clk), .main_rst(main_rst),
    .req0_byte(req0_byte), .req0_valid(req0_valid), .req0_last(req0_last),
    .req0_ready(req0_ready),
    .req1_byte(req1_byte), .req1_valid(req1_valid), .req1_last(req1_last),
    .req1_ready(req1_ready),
    .eth_byte(eth_byte), .input_ready(input_ready), .grant(grant),
    .frame_abort(frame_abort), .busy(busy)
  );

  udp_rx_arbiter #(.IFG_CYCLES(0), .TIMEOUT_CYCLES(255)) dut2 (
    .main_clk(main_clk), .main_rst(b_rst),
    .req0_byte(b0_byte), .req0_valid(b0_valid), .req0_last(b0_last),
    .req0_ready(b0_ready),
    .req1_byte(8'h00), .req1_valid(1'b0), .req1_last(1'b0),
    .req1_ready(b1_ready),
    .eth_byte(b_eth), .input_ready(b_ir), .grant(b_grant),
    .frame_abort(b_abort), .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge main_clk) cyc++;

  function automatic logic [7:0] fb(input int fid, input int i);
    if (i < 7)       return 8'h55;
    else if (i == 7) return 8'hD5;
    else             return 8'(fid * 37 + i * 5 + 1);
  endfunction

  // scoreboard and monitor state
  logic [7:0] sb_q[$];
  logic [1:0] grant_log[$];
  int         delta_log[$];
  bit         sb_en = 1'b1;
  bit         mon_on = 1'b0;
  int         abort_cnt = 0, abort_cyc = 0, strobe_cnt = 0, last_end = 0;
  logic [1:0] abort_grant = 2'b00;
  logic       abort_busy = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic       mon_x;
  logic [7:0] mon_exp;

  always @(negedge main_clk) begin
    if (mon_on) begin
      total++;
      if ((req0_ready && req1_ready) !== 1'b0) begin
        bad++; $display("FAIL both_ready got=%b%b want=not both", req0_ready, req1_ready);
      end
      total++;
      if (input_ready !== prev_xfer) begin
        bad++; $display("FAIL strobe_latency cyc=%0d got=%b want=%b", cyc, input_ready, prev_xfer);
      end
      if (input_ready === 1'b1) begin
        strobe_cnt++;
        if (sb_en) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++; $display("FAIL sb_extra got=%h want=no byte", eth_byte);
          end else begin
            mon_exp = sb_q.pop_front();
            if (eth_byte !== mon_exp) begin
              bad++; $display("FAIL sb_byte cyc=%0d got=%h want=%h", cyc, eth_byte, mon_exp);
            end
          end
        end
      end
      mon_x = !main_rst && ((req0_valid && req0_ready) || (req1_valid && req1_ready));
      if (mon_x && ((req0_ready && req0_last) || (req1_ready && req1_last))) last_end = cyc;
      prev_xfer = mon_x;
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        grant_log.push_back(grant);
        delta_log.push_back(cyc - last_end);
      end
      prev_grant = grant;
      if (frame_abort === 1'b1) begin
        abort_cnt++; abort_cyc = cyc; abort_grant = grant; abort_busy = busy;
      end
    end
  end

  task automatic send_bytes(input int n, input int fid, input int first,
                            input int cnt, input int len);
    for (int i = first; i < first + cnt; i++) begin
      bit acc;
      int w;
      acc = 1'b0;
      w = 0;
      if (n == 0) begin
        req0_byte = fb(fid, i); req0_last = (i == len - 1); req0_valid = 1'b1;
      end else begin
        req1_byte = fb(fid, i); req1_last = (i == len - 1); req1_valid = 1'b1;
      end
      while (!acc) begin
        @(negedge main_clk);
        acc = (n == 0) ? req0_ready : req1_ready;
        @(posedge main_clk); #1;
        w++;
        if (!acc && w > 2000) begin
          total++; bad++;
          $display("FAIL accept_timeout req=%0d byte=%0d got=no ready want=ready", n, i);
          if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
          return;
        end
      end
    end
    if (n == 0) begin req0_valid = 1'b0; req0_last = 1'b0; end
    else        begin req1_valid = 1'b0; req1_last = 1'b0; end
  endtask

  task automatic push_frame(input int fid, input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) sb_q.push_back(fb(fid, i));
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
    main_rst = 1'b1;
    repeat (2) @(posedge main_clk);
    #1 main_rst = 1'b0;
    sb_q.delete(); grant_log.delete(); delta_log.delete();
    abort_cnt = 0; strobe_cnt = 0;
  endtask

  task automatic test_reset();
    main_rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
    req0_byte = 8'h00; req1_byte = 8'h00;
    repeat (2) @(posedge main_clk);
    @(negedge main_clk);
    total++;
    if ({grant, input_ready, frame_abort, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {grant, input_ready, frame_abort, busy});
    end
    total++;
    if (eth_byte !== 8'h00) begin
      bad++; $display("FAIL reset_byte got=%h want=00", eth_byte);
    end
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
    @(posedge main_clk); #1 main_rst = 1'b0;
    mon_on = 1'b1;
    repeat (5) @(negedge main_clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_stays got=%b want=0", busy);
    end
  endtask

  task automatic test_single();
    int s0, bc;
    do_reset();
    push_frame(1, 0, 58);
    s0 = strobe_cnt;
    send_bytes(0, 1, 0, 58, 58);
    bc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge main_clk);
      if (busy === 1'b1) begin
        bc++;
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
          bad++; $display("FAIL gap_ready got=%b want=00", {req0_ready, req1_ready});
        end
      end
    end
    total++;
    if (bc !== 4) begin bad++; $display("FAIL single_gap got=%0d want=4", bc); end
    total++;
    if (strobe_cnt - s0 !== 58) begin bad++; $display("FAIL single_strobes got=%0d want=58", strobe_cnt - s0); end
    total++;
    if (grant_log.size() != 1 || grant_log[0] !== 2'b01) begin
      bad++; $display("FAIL single_grant got=%0d entries want=one 01", grant_log.size());
    end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL single_left got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g[6];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int f = 0; f < 3; f++) begin push_frame(10 + f, 0, 20); push_frame(20 + f, 0, 20); end
    fork
      begin for (int f = 0; f < 3; f++) send_bytes(0, 10 + f, 0, 20, 20); end
      begin for (int f = 0; f < 3; f++) send_bytes(1, 20 + f, 0, 20, 20); end
    join
    repeat (8) @(negedge main_clk);
    total++;
    if (grant_log.size() != 6) begin
      bad++; $display("FAIL rr_count got=%0d want=6", grant_log.size());
    end else begin
      for (int f = 0; f < 6; f++) begin
        total++;
        if (grant_log[f] !== exp_g[f]) begin
          bad++; $display("FAIL rr_grant idx=%0d got=%b want=%b", f, grant_log[f], exp_g[f]);
        end
        if (f > 0) begin
          total++;
          if (delta_log[f] !== 6) begin
            bad++; $display("FAIL rr_ifg idx=%0d got=%0d want=6", f, delta_log[f]);
          end
        end
      end
    end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL rr_left got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_timeout();
    int r1_end;
    do_reset();
    push_frame(30, 0, 10);
    push_frame(31, 0, 16);
    r1_end = 0;
    fork
      begin send_bytes(1, 30, 0, 10, 58); r1_end = cyc - 1; end
      begin
        int w;
        w = 0;
        while (grant !== 2'b10 && w < 50) begin @(negedge main_clk); w++; end
        send_bytes(0, 31, 0, 16, 16);
      end
    join
    repeat (8) @(negedge main_clk);
    total++;
    if (abort_cnt !== 1) begin bad++; $display("FAIL abort_pulses got=%0d want=1", abort_cnt); end
    total++;
    if (abort_cyc - r1_end !== 256) begin
      bad++; $display("FAIL abort_time got=%0d want=256", abort_cyc - r1_end);
    end
    total++;
    if ({abort_grant, abort_busy} !== 3'b001) begin
      bad++; $display("FAIL abort_state got=%b want=001", {abort_grant, abort_busy});
    end
    total++;
    if (grant_log.size() != 2 || grant_log[0] !== 2'b10 || grant_log[1] !== 2'b01) begin
      bad++; $display("FAIL abort_regrant got=%0d entries want=10 then 01", grant_log.size());
    end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL abort_left got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_stall_edge();
    int s0;
    do_reset();
    push_frame(40, 0, 20);
    s0 = strobe_cnt;
    send_bytes(0, 40, 0, 10, 20);
    repeat (254) @(posedge main_clk);
    #1;
    send_bytes(0, 40, 10, 10, 20);
    repeat (8) @(negedge main_clk);
    total++;
    if (abort_cnt !== 0) begin bad++; $display("FAIL stall254_abort got=%0d want=0", abort_cnt); end
    total++;
    if (strobe_cnt - s0 !== 20) begin bad++; $display("FAIL stall254_strobes got=%0d want=20", strobe_cnt - s0); end
    total++;
    if (grant_log.size() !== 1) begin bad++; $display("FAIL stall254_grants got=%0d want=1", grant_log.size()); end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    sb_en = 1'b0;
    send_bytes(1, 50, 0, 20, 58);
    req1_byte = fb(50, 20); req1_valid = 1'b1;
    req0_byte = fb(51, 0); req0_valid = 1'b1; req0_last = 1'b0;
    main_rst = 1'b1;
    @(posedge main_clk); #1 main_rst = 1'b0;
    @(negedge main_clk);
    total++;
    if ({grant, input_ready, frame_abort, busy, req0_ready, req1_ready} !== 7'b0) begin
      bad++; $display("FAIL midreset_ctrl got=%b want=0000000",
                      {grant, input_ready, frame_abort, busy, req0_ready, req1_ready});
    end
    total++;
    if (eth_byte !== 8'h00) begin bad++; $display("FAIL midreset_byte got=%h want=00", eth_byte); end
    w = 0;
    while (grant === 2'b00 && w < 20) begin @(negedge main_clk); w++; end
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL midreset_grant got=%b want=01", grant); end
    total++;
    if (abort_cnt !== 0) begin bad++; $display("FAIL midreset_abort got=%0d want=0", abort_cnt); end
    do_reset();
    sb_en = 1'b1;
  endtask

  task automatic test_ifg0();
    logic [7:0] exp_q[$];
    int cnt, gaps, busy_lo, prev_c;
    for (int f = 0; f < 2; f++) for (int i = 0; i < 12; i++) exp_q.push_back(fb(60 + f, i));
    cnt = 0; gaps = 0; busy_lo = 0; prev_c = 0;
    b0_valid = 1'b0; b0_last = 1'b0; b0_byte = 8'h00;
    b_rst = 1'b1;
    repeat (2) @(posedge main_clk);
    #1 b_rst = 1'b0;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          for (int i = 0; i < 12; i++) begin
            bit acc;
            int w;
            acc = 1'b0; w = 0;
            b0_byte = fb(60 + f, i); b0_last = (i == 11); b0_valid = 1'b1;
            while (!acc && w < 200) begin
              @(negedge main_clk); acc = b0_ready;
              @(posedge main_clk); #1; w++;
            end
            if (!acc) begin
              total++; bad++; $display("FAIL ifg0_accept byte=%0d got=no ready want=ready", i);
            end
          end
          b0_valid = 1'b0; b0_last = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 80; k++) begin
          @(negedge main_clk);
          if (b_ir === 1'b1) begin
            if (cnt > 0 && cyc - prev_c > 1) gaps += cyc - prev_c - 1;
            prev_c = cyc;
            total++;
            if (cnt >= 24) begin
              bad++; $display("FAIL ifg0_extra got=%h want=no byte", b_eth);
            end else if (b_eth !== exp_q[cnt]) begin
              bad++; $display("FAIL ifg0_byte idx=%0d got=%h want=%h", cnt, b_eth, exp_q[cnt]);
            end
            cnt++;
          end
          if (cnt > 0 && cnt < 24 && b_busy === 1'b0) busy_lo++;
        end
      end
    join
    total++;
    if (cnt !== 24) begin bad++; $display("FAIL ifg0_strobes got=%0d want=24", cnt); end
    total++;
    if (gaps !== 1) begin bad++; $display("FAIL ifg0_bubble got=%0d want=1", gaps); end
    total++;
    if (busy_lo !== 1) begin bad++; $display("FAIL ifg0_idle got=%0d want=1", busy_lo); end
  endtask

  initial begin
    b_rst = 1'b1; b0_valid = 1'b0; b0_last = 1'b0; b0_byte = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stall_edge();
    test_reset_mid();
    test_ifg0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
